// File: rtl/mips_alu_pkg.sv
// Shared ALU encodings for the ID/EX control issuer and the EX-stage ALU.
// Every ALU control code, ALUOp class and supported funct/opcode is defined here.
package mips_alu_pkg;

    // ALU control codes driven on ALUCT
    localparam logic [3:0] ALUCT_AND = 4'b0000;
    localparam logic [3:0] ALUCT_OR  = 4'b0001;
    localparam logic [3:0] ALUCT_ADD = 4'b0010;
    localparam logic [3:0] ALUCT_SUB = 4'b0110;
    localparam logic [3:0] ALUCT_SLT = 4'b0111;
    localparam logic [3:0] ALUCT_NOR = 4'b1100;
    localparam logic [3:0] ALUCT_XOR = 4'b1101;

    // Main-control ALUOp classes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    // R-type funct fields
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;

    // I-type opcodes decoded under ALUOp 11
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational ALU-control decode: ALUOp/Opcode/Funct -> {ALU control code, illegal}.
// Unsupported encodings fall back to ADD so the ALU always sees a defined operation.
module mips_alu_decode
    import mips_alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] aluct,
    output logic       illegal
);

    always_comb begin
        aluct   = ALUCT_ADD;
        illegal = 1'b0;
        unique case (alu_op)
            ALUOP_ADD: aluct = ALUCT_ADD;
            ALUOP_SUB: aluct = ALUCT_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD, FUNCT_ADDU: aluct = ALUCT_ADD;
                    FUNCT_SUB, FUNCT_SUBU: aluct = ALUCT_SUB;
                    FUNCT_AND:             aluct = ALUCT_AND;
                    FUNCT_OR:              aluct = ALUCT_OR;
                    FUNCT_XOR:             aluct = ALUCT_XOR;
                    FUNCT_NOR:             aluct = ALUCT_NOR;
                    FUNCT_SLT:             aluct = ALUCT_SLT;
                    default: begin
                        aluct   = ALUCT_ADD;
                        illegal = 1'b1;
                    end
                endcase
            end
            ALUOP_ITYPE: begin
                case (opcode)
                    OPC_ADDI, OPC_ADDIU: aluct = ALUCT_ADD;
                    OPC_SLTI:            aluct = ALUCT_SLT;
                    OPC_ANDI:            aluct = ALUCT_AND;
                    OPC_ORI:             aluct = ALUCT_OR;
                    OPC_XORI:            aluct = ALUCT_XOR;
                    default: begin
                        aluct   = ALUCT_ADD;
                        illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mips_alu_ctrl_stage.sv
// ID/EX ALU-control pipeline register with stall/flush and a saturating
// counter of captured illegal encodings.
module mips_alu_ctrl_stage
    import mips_alu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       Opcode,
    input  logic [5:0]       Funct,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             illegal_clr,
    output logic             ex_valid,
    output logic [3:0]       ALUCT,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [3:0]       dec_aluct;
    logic             dec_illegal;

    logic             ex_valid_q,   ex_valid_d;
    logic [3:0]       aluct_q,      aluct_d;
    logic             ex_illegal_q, ex_illegal_d;
    logic [CNT_W-1:0] ill_cnt_q,    ill_cnt_d;
    logic             ill_inc;

    mips_alu_decode u_decode (
        .alu_op  (ALUOp),
        .opcode  (Opcode),
        .funct   (Funct),
        .aluct   (dec_aluct),
        .illegal (dec_illegal)
    );

    // Flush outranks Stall; a non-valid, non-stalled cycle inserts a bubble
    always_comb begin
        ex_valid_d   = 1'b0;
        aluct_d      = ALUCT_ADD;
        ex_illegal_d = 1'b0;
        if (Flush) begin
            ex_valid_d   = 1'b0;
            aluct_d      = ALUCT_ADD;
            ex_illegal_d = 1'b0;
        end else if (Stall) begin
            ex_valid_d   = ex_valid_q;
            aluct_d      = aluct_q;
            ex_illegal_d = ex_illegal_q;
        end else if (id_valid) begin
            ex_valid_d   = 1'b1;
            aluct_d      = dec_aluct;
            ex_illegal_d = dec_illegal;
        end
    end

    // A clear coinciding with an illegal capture leaves that capture counted
    always_comb begin
        ill_inc   = id_valid & ~Stall & ~Flush & dec_illegal;
        ill_cnt_d = ill_cnt_q;
        if (illegal_clr) begin
            ill_cnt_d = ill_inc ? CNT_W'(1) : '0;
        end else if (ill_inc && (ill_cnt_q != CNT_MAX)) begin
            ill_cnt_d = ill_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q   <= 1'b0;
            aluct_q      <= ALUCT_ADD;
            ex_illegal_q <= 1'b0;
            ill_cnt_q    <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            aluct_q      <= aluct_d;
            ex_illegal_q <= ex_illegal_d;
            ill_cnt_q    <= ill_cnt_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ALUCT         = aluct_q;
    assign ex_illegal    = ex_illegal_q;
    assign illegal_count = ill_cnt_q;

endmodule

// File: tb/tb_mips_alu_ctrl_stage.sv
// Directed bench for mips_alu_ctrl_stage: legal-decode table swept back to back,
// then hand-written stall/flush/saturation/clear/async-reset sequences.
module tb_mips_alu_ctrl_stage;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic [1:0]       ALUOp;
    logic [5:0]       Opcode;
    logic [5:0]       Funct;
    logic             Stall;
    logic             Flush;
    logic             illegal_clr;
    logic             ex_valid;
    logic [3:0]       ALUCT;
    logic             ex_illegal;
    logic [CNT_W-1:0] illegal_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    mips_alu_ctrl_stage #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .ALUOp         (ALUOp),
        .Opcode        (Opcode),
        .Funct         (Funct),
        .Stall         (Stall),
        .Flush         (Flush),
        .illegal_clr   (illegal_clr),
        .ex_valid      (ex_valid),
        .ALUCT         (ALUCT),
        .ex_illegal    (ex_illegal),
        .illegal_count (illegal_count)
    );

    typedef struct {
        logic [1:0] aluop;
        logic [5:0] opcode;
        logic [5:0] funct;
        logic [3:0] exp_aluct;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic v, input logic [3:0] a,
                           input logic il, input int cnt);
        chk({name, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, v});
        chk({name, ".ALUCT"}, {28'd0, ALUCT}, {28'd0, a});
        chk({name, ".ex_illegal"}, {31'd0, ex_illegal}, {31'd0, il});
        chk({name, ".count"}, {24'd0, illegal_count}, cnt);
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] opc,
                         input logic [5:0] fn, input logic st, input logic fl, input logic clr);
        id_valid = v; ALUOp = op; Opcode = opc; Funct = fn;
        Stall = st; Flush = fl; illegal_clr = clr;
    endtask

    initial begin
        vecs[0]  = '{2'b10, 6'h00, 6'h20, 4'b0010};
        vecs[1]  = '{2'b10, 6'h00, 6'h21, 4'b0010};
        vecs[2]  = '{2'b10, 6'h00, 6'h22, 4'b0110};
        vecs[3]  = '{2'b10, 6'h00, 6'h23, 4'b0110};
        vecs[4]  = '{2'b10, 6'h00, 6'h24, 4'b0000};
        vecs[5]  = '{2'b10, 6'h00, 6'h25, 4'b0001};
        vecs[6]  = '{2'b10, 6'h00, 6'h26, 4'b1101};
        vecs[7]  = '{2'b10, 6'h00, 6'h27, 4'b1100};
        vecs[8]  = '{2'b10, 6'h00, 6'h2A, 4'b0111};
        vecs[9]  = '{2'b00, 6'h3F, 6'h24, 4'b0010};
        vecs[10] = '{2'b01, 6'h3F, 6'h25, 4'b0110};
        vecs[11] = '{2'b11, 6'h08, 6'h3F, 4'b0010};
        vecs[12] = '{2'b11, 6'h09, 6'h3F, 4'b0010};
        vecs[13] = '{2'b11, 6'h0A, 6'h3F, 4'b0111};
        vecs[14] = '{2'b11, 6'h0C, 6'h3F, 4'b0000};
        vecs[15] = '{2'b11, 6'h0D, 6'h3F, 4'b0001};
        vecs[16] = '{2'b11, 6'h0E, 6'h3F, 4'b1101};

        reset = 1'b1;
        drive(1'b0, 2'b00, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk_out("reset", 1'b0, 4'b0010, 1'b0, 0);
        reset = 1'b0;

        drive(1'b1, 2'b10, 6'h00, 6'h2A, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("first_slt", 1'b1, 4'b0111, 1'b0, 0);

        // Back-to-back legal decodes: each result exactly one edge later
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, vecs[i].aluop, vecs[i].opcode, vecs[i].funct, 1'b0, 1'b0, 1'b0);
            tick();
            chk_out($sformatf("vec%0d", i), 1'b1, vecs[i].exp_aluct, 1'b0, 0);
        end

        drive(1'b0, 2'b10, 6'h00, 6'h3F, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("idle_bubble", 1'b0, 4'b0010, 1'b0, 0);

        // Illegal R-type captures, saturating at 255
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            drive(1'b1, 2'b10, 6'h00, 6'h3F, 1'b0, 1'b0, 1'b0);
            tick();
            if (exp_cnt < 255) exp_cnt++;
            if (i < 2 || i >= 253)
                chk_out($sformatf("ill_r%0d", i), 1'b1, 4'b0010, 1'b1, exp_cnt);
        end
        chk("sat_255", {24'd0, illegal_count}, 32'd255);

        drive(1'b0, 2'b00, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1);
        tick();
        exp_cnt = 0;
        chk_out("clr", 1'b0, 4'b0010, 1'b0, exp_cnt);

        // Reach 5 with illegal I-type opcodes
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b11, 6'h3F, 6'h20, 1'b0, 1'b0, 1'b0);
            tick();
            exp_cnt++;
        end
        chk_out("ill_i_5", 1'b1, 4'b0010, 1'b1, 5);

        drive(1'b1, 2'b10, 6'h00, 6'h3F, 1'b0, 1'b0, 1'b1);
        tick();
        exp_cnt = 1;
        chk_out("clr_and_inc", 1'b1, 4'b0010, 1'b1, exp_cnt);

        // Capture SUB then stall 3 cycles while AND is presented
        drive(1'b1, 2'b01, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("sub_cap", 1'b1, 4'b0110, 1'b0, exp_cnt);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b10, 6'h00, 6'h24, 1'b1, 1'b0, 1'b0);
            tick();
            chk_out($sformatf("stall%0d", i), 1'b1, 4'b0110, 1'b0, exp_cnt);
        end

        drive(1'b1, 2'b10, 6'h00, 6'h3F, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("stall_ill", 1'b1, 4'b0110, 1'b0, exp_cnt);

        drive(1'b1, 2'b10, 6'h00, 6'h3F, 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("flush_ill", 1'b0, 4'b0010, 1'b0, exp_cnt);

        drive(1'b1, 2'b10, 6'h00, 6'h27, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("nor_cap", 1'b1, 4'b1100, 1'b0, exp_cnt);
        drive(1'b1, 2'b10, 6'h00, 6'h24, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("stall_flush", 1'b0, 4'b0010, 1'b0, exp_cnt);

        // Async reset mid-cycle while EX holds a valid instruction
        drive(1'b1, 2'b10, 6'h00, 6'h3F, 1'b0, 1'b0, 1'b0);
        tick();
        exp_cnt++;
        chk_out("pre_rst", 1'b1, 4'b0010, 1'b1, exp_cnt);
        drive(1'b1, 2'b10, 6'h00, 6'h25, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("pre_rst_or", 1'b1, 4'b0001, 1'b0, exp_cnt);
        #2 reset = 1'b1;
        #1;
        exp_cnt = 0;
        chk_out("async_rst", 1'b0, 4'b0010, 1'b0, exp_cnt);
        #1 reset = 1'b0;
        drive(1'b1, 2'b10, 6'h00, 6'h27, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("post_rst", 1'b1, 4'b1100, 1'b0, exp_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_alu_ctrl_stage.md
# mips_alu_ctrl_stage

Registered ALU-control issuer that sits at the ID/EX boundary and drives the 4-bit ALU control code (ALUCT) consumed by the EX-stage ALU. It decodes the main-control ALUOp class together with opcode and funct fields into one of the seven supported ALU operations. It captures the result in a stallable, flushable pipeline register. It flags and counts unsupported encodings so illegal R-type and immediate instructions are visible to the hazard/exception logic.

## Interface
Parameters:
- CNT_W, 8, width of the saturating illegal-instruction counter (≥2)

Ports:
- clk  in  1  rising-edge clock; single clock domain
- reset  in  1  asynchronous, active-high; clears all state
- id_valid  in  1  decode stage presents a valid instruction this cycle
- ALUOp  in  2  main-control class: 00 add (lw/sw/addi-class), 01 sub (beq/bne), 10 R-type (use Funct), 11 I-type logic/compare (use Opcode)
- Opcode  in  6  instruction bits [31:26]
- Funct  in  6  instruction bits [5:0]
- Stall  in  1  hold the EX-stage register contents
- Flush  in  1  replace the EX-stage register contents with a bubble
- illegal_clr  in  1  synchronous clear of illegal_count
- ex_valid  out  1  EX stage holds a valid instruction
- ALUCT  out  4  registered ALU control code
- ex_illegal  out  1  EX-stage instruction had an unsupported encoding
- illegal_count  out  CNT_W  saturating count of captured illegal instructions

## Operation
- ALUCT encodings: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, XOR 1101.
- ALUOp 00 → ADD. ALUOp 01 → SUB. Both are always legal.
- ALUOp 10 funct map: 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT. Any other funct is illegal.
- ALUOp 11 opcode map: 0x08/0x09 ADD, 0x0A SLT, 0x0C AND, 0x0D OR, 0x0E XOR. Any other opcode is illegal.
- An illegal decode produces ALUCT ADD (0010) with illegal=1.
- Per-edge register update, in priority order:
  - Flush: bubble (ex_valid=0, ALUCT=0010, ex_illegal=0).
  - Stall: hold.
  - id_valid=1: capture the decode (ex_valid=1).
  - Otherwise: bubble.
- Flush beats Stall.
- Counter increment condition: id_valid & ~Stall & ~Flush & illegal. The counter saturates at 2^CNT_W−1.
- illegal_clr sets the count to 0. If illegal_clr and an increment happen in the same cycle, the count becomes 1.
- Decode is a pure function of the inputs and does not depend on id_valid. When id_valid=0, Opcode and Funct are don't-care.

## Timing
- Reset (async assert, sync-safe deassert by system) gives: ex_valid=0, ALUCT=0010, ex_illegal=0, illegal_count=0.
- Latency: 1 cycle from ID inputs to ALUCT/ex_valid/ex_illegal.
- illegal_count reflects a capture 1 cycle after it occurs.
- Stall held for N cycles keeps the outputs constant for N cycles, and inputs are ignored during that time.
- Back-to-back valid instructions give one result per cycle with no bubbles.
- Reset asserted mid-stall or mid-flush takes effect immediately. The first edge after reset deasserts follows the normal priority rules.
- A saturated counter stays at its maximum until illegal_clr or reset.

## Structure
- Shared package mips_alu_pkg holds:
  - ALUCT localparams (AND, OR, ADD, SUB, SLT, NOR, XOR).
  - ALUOp class constants.
  - Supported funct and opcode constants.
- The ALU consumes the same package. Encodings are defined only there.
- Sub-module mips_alu_decode is purely combinational: ALUOp/Opcode/Funct → {ALUCT, illegal}. The top level holds the pipeline register and the counter.

## Test plan
- Reset, then id_valid=1, ALUOp=10, Funct=0x2A → next cycle ALUCT=0111, ex_valid=1, ex_illegal=0, illegal_count=0.
- Sweep all 9 legal functs, then ALUOp 00, 01, and 11 with opcodes 0x08/0x0A/0x0C/0x0D/0x0E back-to-back → each code appears exactly one cycle later, with no gaps.
- ALUOp=10, Funct=0x3F (illegal) → ALUCT=0010, ex_illegal=1, and the count increments by 1. Repeat 2^CNT_W+3 times → the count holds at 255 for CNT_W=8.
- Capture SUB, then Stall=1 for 3 cycles while the inputs present AND → ALUCT stays 0110. Assert Stall and Flush together → bubble (ex_valid=0, ALUCT=0010).
- Illegal capture and illegal_clr in the same cycle with count=5 → count=1. Stalled illegal or flushed illegal → no increment.
- Assert reset asynchronously mid-cycle while ex_valid=1 → outputs return to their reset values before the next clock edge.
